// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the circular FIFO: default geometry,
// pointer-width derivation and the occupancy type.
package fifo_pkg;

    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_DEPTH = 8;

    function automatic int fifo_aw(input int depth);
        return $clog2(depth);
    endfunction

    localparam int FIFO_AW = fifo_aw(FIFO_DEPTH);

    // Occupancy needs one extra bit so that a full FIFO (DEPTH) is representable.
    typedef logic [FIFO_AW:0] count_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port and one
// registered read port. Contents and read register are not reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = fifo_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fifo_buffer.sv
// Circular FIFO with registered output, simultaneous read/write and sticky
// overflow/underflow flags. Holds pointers, occupancy and accept logic.
module fifo_buffer
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = fifo_aw(DEPTH)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] DataIn,
    input  logic             W,
    output logic             FULL,
    input  logic             R,
    output logic [WIDTH-1:0] DataOut,
    output logic             Empty,
    output logic [AW:0]      Count,
    output logic             Overflow,
    output logic             Underflow,
    input  logic             ClrErr
);

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             dvld_q, dvld_d;
    logic             wr_ok, rd_ok;
    logic [WIDTH-1:0] mem_rdata;

    // Flags come only from registered occupancy, never from W/R.
    assign FULL  = (count_q == CNT_FULL);
    assign Empty = (count_q == '0);

    assign wr_ok = W && !FULL;
    assign rd_ok = R && !Empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dvld_d   = dvld_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            dvld_d   = 1'b1;
        end
        if (wr_ok && !rd_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CNT_ONE;
        end
        // Set takes priority over a same-cycle clear.
        ovf_d = (ovf_q && !ClrErr) || (W && FULL);
        udf_d = (udf_q && !ClrErr) || (R && Empty);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            dvld_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            dvld_q   <= dvld_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (Clk),
        .we    (wr_ok),
        .waddr (wr_ptr_q),
        .wdata (DataIn),
        .re    (rd_ok),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    // The read register has no reset; DataOut reads as zero until the first
    // read after reset.
    assign DataOut   = dvld_q ? mem_rdata : '0;
    assign Count     = count_q;
    assign Overflow  = ovf_q;
    assign Underflow = udf_q;

endmodule

// File: tb/tb_fifo_buffer.sv
// Bench for fifo_buffer: directed scenarios plus random traffic, compared
// against a queue-based reference model.
module tb_fifo_buffer;
    import fifo_pkg::*;

    localparam int DEPTH = 8;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [7:0] DataIn;
    logic       W, R, ClrErr;
    logic       FULL, Empty, Overflow, Underflow;
    logic [7:0] DataOut;
    count_t     Count;

    int errs   = 0;
    int checks = 0;

    logic [7:0] mq[$];
    logic [7:0] m_dout;
    bit         m_ovf, m_udf;

    fifo_buffer dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .DataIn    (DataIn),
        .W         (W),
        .FULL      (FULL),
        .R         (R),
        .DataOut   (DataOut),
        .Empty     (Empty),
        .Count     (Count),
        .Overflow  (Overflow),
        .Underflow (Underflow),
        .ClrErr    (ClrErr)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(Count), 32'(mq.size()));
        chk({tag, ".empty"}, 32'(Empty), 32'(mq.size() == 0));
        chk({tag, ".full"},  32'(FULL),  32'(mq.size() == DEPTH));
        chk({tag, ".dout"},  32'(DataOut), 32'(m_dout));
        chk({tag, ".ovf"},   32'(Overflow),  32'(m_ovf));
        chk({tag, ".udf"},   32'(Underflow), 32'(m_udf));
    endtask

    function automatic void model_reset();
        mq.delete();
        m_dout = 8'h00;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endfunction

    // One clock: drive at negedge, advance the model at posedge, check after.
    task automatic step(input bit w, input bit r, input logic [7:0] din,
                        input bit clr, input string tag);
        bit full, empty;
        @(negedge Clk);
        W = w; R = r; DataIn = din; ClrErr = clr;
        @(posedge Clk);
        full  = (mq.size() == DEPTH);
        empty = (mq.size() == 0);
        if (r && !empty) m_dout = mq.pop_front();
        if (w && !full)  mq.push_back(din);
        m_ovf = (m_ovf && !clr) || (w && full);
        m_udf = (m_udf && !clr) || (r && empty);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        #2;
        Reset_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        @(negedge Clk);
        W = 0; R = 0; ClrErr = 0;
        Reset_n = 1'b1;
    endtask

    initial begin
        Reset_n = 1'b0; W = 0; R = 0; ClrErr = 0; DataIn = 8'h00;
        model_reset();
        #13;
        check_all("rst_init");
        Reset_n = 1'b1;

        // Fill and drain
        for (int i = 1; i <= 8; i++) step(1, 0, 8'(i * 8'h11), 0, "fill");
        chk("fill.full_hi", 32'(FULL), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 8'h00, 0, "drain");
            chk("drain.order", 32'(DataOut), 32'(i * 8'h11));
        end
        chk("drain.empty_hi", 32'(Empty), 32'd1);

        // Overflow, drain, clear
        for (int i = 0; i < 8; i++) step(1, 0, 8'(8'h20 + i), 0, "ovf_fill");
        step(1, 0, 8'h99, 0, "ovf_write");
        chk("ovf.set", 32'(Overflow), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 8'h00, 0, "ovf_drain");
            chk("ovf.no99", 32'(DataOut == 8'h99), 32'd0);
        end
        step(0, 0, 8'h00, 1, "ovf_clr");
        chk("ovf.cleared", 32'(Overflow), 32'd0);

        // Simultaneous at full
        for (int i = 0; i < 8; i++) step(1, 0, 8'(8'h30 + i), 0, "sf_fill");
        step(1, 1, 8'hAA, 0, "sim_full");
        chk("sim_full.dout", 32'(DataOut), 32'h30);
        chk("sim_full.cnt",  32'(Count), 32'd7);
        for (int i = 0; i < 7; i++) step(0, 1, 8'h00, 0, "sf_drain");
        step(0, 0, 8'h00, 1, "sf_clr");

        // Simultaneous at empty
        step(1, 1, 8'h5A, 0, "sim_empty");
        chk("sim_empty.udf", 32'(Underflow), 32'd1);
        chk("sim_empty.dout_held", 32'(DataOut), 32'h37);
        step(0, 1, 8'h00, 0, "sim_empty_rd");
        chk("sim_empty.rd5a", 32'(DataOut), 32'h5A);
        step(0, 0, 8'h00, 1, "se_clr");

        // Wrap-around streaming at constant occupancy 3
        for (int i = 1; i <= 3; i++) step(1, 0, 8'(i), 0, "wrap_pre");
        for (int i = 4; i <= 15; i++) begin
            step(1, 1, 8'(i), 0, "wrap");
            chk("wrap.cnt3", 32'(Count), 32'd3);
            chk("wrap.order", 32'(DataOut), 32'(i - 3));
        end
        for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0, "wrap_drain");

        // Reset mid-operation with data in flight
        step(1, 0, 8'hC3, 0, "pre_rst");
        step(1, 1, 8'hC4, 0, "pre_rst");
        do_reset("rst_mid");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
                 8'($urandom), ($urandom_range(0, 19) == 0), "rand");
            if (n == 250) do_reset("rst_rand");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/fifo_buffer.md
Name: fifo_buffer

Overview:
Circular first-in/first-out buffer; the queue-ordered counterpart to the team's push/pop stack, with the same W/R/FULL/Empty/Count handshake so either can sit between a byte producer and consumer. Data leaves in arrival order through a registered output. It adds simultaneous read/write throughput and sticky overflow/underflow error flags.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 8, number of entries; must be a power of two, minimum 2
AW, 3, pointer width = log2(DEPTH)

Ports:
Clk  input  1  rising-edge clock
Reset_n  input  1  asynchronous active-low reset
DataIn  input  WIDTH  write data, sampled when a write is accepted
W  input  1  write request
FULL  output  1  high when Count == DEPTH
R  input  1  read request
DataOut  output  WIDTH  registered read data
Empty  output  1  high when Count == 0
Count  output  AW+1  current occupancy, 0..DEPTH
Overflow  output  1  sticky flag: a write was attempted while FULL
Underflow  output  1  sticky flag: a read was attempted while Empty
ClrErr  input  1  synchronous clear of Overflow and Underflow

Behaviour:
- Reset_n low: Count=0, wr_ptr=0, rd_ptr=0, DataOut=0, Overflow=0, Underflow=0, all immediately and without waiting for Clk. Storage is not reset.
- Write accept: wr_ok = W && !FULL. On the edge, mem[wr_ptr] <= DataIn and wr_ptr <= wr_ptr+1.
- Read accept: rd_ok = R && !Empty. On the edge, DataOut <= mem[rd_ptr] and rd_ptr <= rd_ptr+1.
- Read latency: 1 cycle. DataOut is valid in the cycle after the read-accept edge and holds its value until the next accepted read.
- FULL and Empty are decoded combinationally from the registered Count only. They never depend on W or R in the same cycle.
- Count update:
  - wr_ok only: +1
  - rd_ok only: -1
  - both: unchanged
  - neither: unchanged
- Pointers: AW bits wide and wrap modulo DEPTH naturally (DEPTH-1 -> 0).
- Full with W=1 and R=1: the read is accepted and the write is rejected. Count decrements, and Overflow is set.
- Empty with W=1 and R=1: the write is accepted and the read is rejected (no write-to-read bypass). Count becomes 1, DataOut is unchanged, and Underflow is set.
- Both accepted, 0 < Count < DEPTH: the read returns the oldest entry and the write stores to wr_ptr. There is no hazard, because wr_ptr != rd_ptr whenever Count is not 0 or DEPTH.
- Rejected write: storage, pointers and Count are untouched; the data is dropped.
- Rejected read: DataOut, pointers and Count are untouched.
- Error flags:
  - Overflow sets on W && FULL; Underflow sets on R && Empty.
  - ClrErr clears both flags.
  - If a set and a clear occur in the same cycle, the set wins.
- Reset asserted mid-operation: the FIFO empties immediately; entries in flight are lost.
- Invariant: Count == (wr_ptr - rd_ptr) mod DEPTH, except when Count == DEPTH, where the pointers are equal.

Decomposition:
- Package fifo_pkg: default WIDTH and DEPTH constants, a function deriving AW from DEPTH, and an occupancy typedef of AW+1 bits.
- Sub-module fifo_mem: DEPTH x WIDTH register array with one synchronous write port (we, waddr, wdata) and one registered read port (re, raddr, rdata). It has no reset.
- fifo_buffer itself holds the pointers, Count, the flag logic, and the accept qualification.

Test Plan:
- Reset: drive Reset_n=0 mid-clock, then release -> Count=0, Empty=1, FULL=0, DataOut=0x00, Overflow=0, Underflow=0, with no Clk edge required.
- Fill and drain: write 0x11..0x88 (8 writes) -> FULL=1 and Count=8. Then 8 reads -> DataOut sequence 0x11..0x88, each one cycle after its read, ending with Empty=1.
- Overflow: with FULL, write 0x99 -> Count stays 8 and Overflow=1. Drain all -> 0x99 never appears. ClrErr for 1 cycle -> Overflow=0.
- Simultaneous at full: with FULL, W=1 (0xAA) and R=1 -> DataOut=oldest entry, Count=7, Overflow=1.
- Simultaneous at empty: with Empty, W=1 (0x5A) and R=1 -> Count=1, DataOut unchanged, Underflow=1. Next read -> DataOut=0x5A.
- Wrap-around: 12 cycles of W=R=1 streaming 0x01..0x0C with Count held at 3 -> output order is preserved across the pointer wrap and Count stays at 3 throughout.
